uart_baud_arbiter: RTL and testbench

UART_BAUD_ARBITER -- requirements
Module: uart_baud_arbiter

---
 rtl/uart_baud_arbiter.sv | 113 +++++++++++
 tb/tb_uart_baud_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_baud_arbiter.sv
// Round-robin arbiter sharing one baud generator between a UART TX and RX.
// Grants end on done, request drop or a baud-tick timeout, then a guard gap.
module uart_baud_arbiter #(
   parameter int unsigned MAX_BAUD  = 1000,
   parameter int unsigned GUARD_CYC = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic tx_req,
   input  logic rx_req,
   input  logic tx_done,
   input  logic rx_done,
   input  logic tick_8x_in,
   input  logic tick_baud_in,
   output logic baud_en,
   output logic tx_gnt,
   output logic rx_gnt,
   output logic tx_tick_8x,
   output logic tx_tick_baud,
   output logic rx_tick_8x,
   output logic rx_tick_baud,
   output logic timeout_err
);

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      GNT_TX,
      GNT_RX,
      GUARD
   } state_t;

   state_t      state, state_nxt;
   logic [15:0] baud_cnt, baud_cnt_nxt;
   logic [7:0]  guard_cnt, guard_cnt_nxt;
   logic        win_rx, win_rx_nxt;
   logic        last_rx, last_rx_nxt;
   logic        timeout_nxt;
   logic        g_rx, g_req, g_done, w_req, baud_hit;

   assign g_rx     = (state == GNT_RX);
   assign g_req    = g_rx ? rx_req : tx_req;
   assign g_done   = g_rx ? rx_done : tx_done;
   assign w_req    = win_rx ? rx_req : tx_req;
   assign baud_hit = tick_baud_in &&
                     (({1'b0, baud_cnt} + 17'd1) == 17'(MAX_BAUD));

   always_comb begin
      state_nxt     = state;
      baud_cnt_nxt  = baud_cnt;
      guard_cnt_nxt = '0;
      win_rx_nxt    = win_rx;
      last_rx_nxt   = last_rx;
      timeout_nxt   = 1'b0;
      unique case (state)
         IDLE: begin
            if (tx_req || rx_req) begin
               state_nxt    = ARM;
               baud_cnt_nxt = '0;
               // on a tie the side not served last wins
               win_rx_nxt   = rx_req && (!tx_req || !last_rx);
            end
         end
         ARM: begin
            if (w_req) state_nxt = win_rx ? GNT_RX : GNT_TX;
            else       state_nxt = GUARD;
         end
         GNT_TX, GNT_RX: begin
            if (tick_baud_in) baud_cnt_nxt = baud_cnt + 16'd1;
            if (g_done || !g_req) begin
               state_nxt   = GUARD;
               last_rx_nxt = g_rx;
            end else if (baud_hit) begin
               state_nxt   = GUARD;
               last_rx_nxt = g_rx;
               timeout_nxt = 1'b1;
            end
         end
         GUARD: begin
            if (guard_cnt == 8'(GUARD_CYC - 1)) state_nxt = IDLE;
            else guard_cnt_nxt = guard_cnt + 8'd1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         baud_cnt    <= '0;
         guard_cnt   <= '0;
         win_rx      <= 1'b0;
         last_rx     <= 1'b1;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         baud_cnt    <= baud_cnt_nxt;
         guard_cnt   <= guard_cnt_nxt;
         win_rx      <= win_rx_nxt;
         last_rx     <= last_rx_nxt;
         timeout_err <= timeout_nxt;
      end
   end

   assign tx_gnt       = (state == GNT_TX);
   assign rx_gnt       = (state == GNT_RX);
   assign baud_en      = tx_gnt || rx_gnt;
   assign tx_tick_8x   = tick_8x_in & tx_gnt;
   assign tx_tick_baud = tick_baud_in & tx_gnt;
   assign rx_tick_8x   = tick_8x_in & rx_gnt;
   assign rx_tick_baud = tick_baud_in & rx_gnt;

endmodule

// File: tb/tb_uart_baud_arbiter.sv
// Bench for uart_baud_arbiter: directed scenarios plus random traffic,
// all checked cycle by cycle against an owner/countdown reference model.
module tb_uart_baud_arbiter;

   localparam int MAXB  = 3;
   localparam int GUARD = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tx_req = 0, rx_req = 0, tx_done = 0, rx_done = 0;
   logic tick_8x_in = 0, tick_baud_in = 0;
   logic baud_en, tx_gnt, rx_gnt;
   logic tx_tick_8x, tx_tick_baud, rx_tick_8x, rx_tick_baud;
   logic timeout_err;

   int n_chk = 0;
   int n_err = 0;

   // model: owner 0=none 1=tx 2=rx; pending winner during arm phase
   int m_own = 0, m_pend = 0, m_guard = 0, m_used = 0, m_last = 2;
   bit m_terr = 0;

   uart_baud_arbiter #(.MAX_BAUD(MAXB), .GUARD_CYC(GUARD)) dut (
      .clk(clk), .rst(rst),
      .tx_req(tx_req), .rx_req(rx_req),
      .tx_done(tx_done), .rx_done(rx_done),
      .tick_8x_in(tick_8x_in), .tick_baud_in(tick_baud_in),
      .baud_en(baud_en), .tx_gnt(tx_gnt), .rx_gnt(rx_gnt),
      .tx_tick_8x(tx_tick_8x), .tx_tick_baud(tx_tick_baud),
      .rx_tick_8x(rx_tick_8x), .rx_tick_baud(rx_tick_baud),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] dut_vec();
      return {baud_en, tx_gnt, rx_gnt, tx_tick_8x, tx_tick_baud,
              rx_tick_8x, rx_tick_baud, timeout_err};
   endfunction

   function automatic logic [7:0] exp_vec();
      logic t, r;
      t = (m_own == 1);
      r = (m_own == 2);
      return {t | r, t, r, tick_8x_in & t, tick_baud_in & t,
              tick_8x_in & r, tick_baud_in & r, m_terr};
   endfunction

   task automatic model_step();
      logic r, d;
      if (rst) begin
         m_own = 0; m_pend = 0; m_guard = 0;
         m_used = 0; m_last = 2; m_terr = 0;
      end else begin
         m_terr = 0;
         if (m_own != 0) begin
            r = (m_own == 1) ? tx_req : rx_req;
            d = (m_own == 1) ? tx_done : rx_done;
            if (d || !r) begin
               m_last = m_own; m_own = 0; m_guard = GUARD;
            end else if (tick_baud_in) begin
               m_used++;
               if (m_used == MAXB) begin
                  m_last = m_own; m_own = 0;
                  m_guard = GUARD; m_terr = 1;
               end
            end
         end else if (m_pend != 0) begin
            r = (m_pend == 1) ? tx_req : rx_req;
            if (r) m_own = m_pend;
            else   m_guard = GUARD;
            m_pend = 0;
            m_used = 0;
         end else if (m_guard > 0) begin
            m_guard--;
         end else if (tx_req || rx_req) begin
            if (tx_req && rx_req) m_pend = (m_last == 1) ? 2 : 1;
            else                  m_pend = tx_req ? 1 : 2;
         end
      end
   endtask

   // one clock: compare at negedge, advance model at posedge
   task automatic cyc();
      @(negedge clk);
      chk("outputs", dut_vec(), exp_vec());
      chk("mutex", tx_gnt & rx_gnt, 0);
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic quiet(input int n);
      tx_req = 0; rx_req = 0; tx_done = 0; rx_done = 0;
      tick_8x_in = 0; tick_baud_in = 0;
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic do_reset();
      rst = 1;
      cyc();
      cyc();
      rst = 0;
   endtask

   initial begin
      int k;
      #1;
      do_reset();
      chk("reset_vec", dut_vec(), 0);
      quiet(3);

      // single tx: grant two cycles after request, guard then idle
      tx_req = 1;
      cyc();
      chk("arm_no_gnt", tx_gnt, 0);
      cyc();
      chk("lat_tx_gnt", tx_gnt, 1);
      chk("lat_baud_en", baud_en, 1);
      cyc(); cyc(); cyc();
      tx_done = 1;
      cyc();
      tx_done = 0; tx_req = 0;
      chk("rel_gnt_low", tx_gnt, 0);
      rx_req = 1;
      k = 0;
      while (!rx_gnt && k < 20) begin
         cyc();
         k++;
      end
      chk("guard_len", k, GUARD + 2);

      // gating during rx grant
      tick_8x_in = 1; #1;
      chk("rx_8x_on", rx_tick_8x, 1);
      chk("tx_8x_off", tx_tick_8x, 0);
      cyc();
      tick_8x_in = 0; #1;
      chk("rx_8x_off", rx_tick_8x, 0);

      // timeout: three baud ticks, no done
      tick_baud_in = 1; cyc();
      tick_baud_in = 0; cyc();
      tick_baud_in = 1; cyc();
      tick_baud_in = 0; cyc();
      chk("no_early_to", timeout_err, 0);
      tick_baud_in = 1; cyc();
      tick_baud_in = 0; rx_req = 0;
      chk("to_pulse", timeout_err, 1);
      chk("to_rx_low", rx_gnt, 0);
      cyc();
      chk("to_one_cyc", timeout_err, 0);
      quiet(8);

      // ticks outside grants are blocked
      tick_8x_in = 1; tick_baud_in = 1; #1;
      chk("idle_gate", dut_vec() & 8'h1e, 0);
      quiet(2);

      // round-robin tie
      do_reset();
      tx_req = 1; rx_req = 1;
      cyc(); cyc();
      chk("tie_tx_first", tx_gnt, 1);
      tx_done = 1; cyc(); tx_done = 0;
      for (int i = 0; i < GUARD + 2; i++) cyc();
      chk("tie_rx_next", rx_gnt, 1);
      tx_done = 1; cyc(); tx_done = 0;
      chk("foreign_done", rx_gnt, 1);
      rx_done = 1; cyc(); rx_done = 0;
      for (int i = 0; i < GUARD + 2; i++) cyc();
      chk("tie_tx_again", tx_gnt, 1);
      quiet(8);

      // done and final tick together: release wins
      tx_req = 1;
      cyc(); cyc();
      tick_baud_in = 1; cyc(); cyc();
      tx_done = 1; cyc();
      tx_done = 0; tick_baud_in = 0;
      chk("done_wins_to", timeout_err, 0);
      chk("done_wins_gnt", tx_gnt, 0);
      quiet(8);

      // reset mid-grant
      tx_req = 1;
      cyc(); cyc();
      chk("pre_rst_gnt", tx_gnt, 1);
      rst = 1; tick_8x_in = 1; tick_baud_in = 1;
      cyc();
      chk("rst_mid_vec", dut_vec(), 0);
      rst = 0;
      quiet(8);

      // random traffic
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 15) == 0) tx_req = ~tx_req;
         if ($urandom_range(0, 15) == 0) rx_req = ~rx_req;
         tx_done      = ($urandom_range(0, 24) == 0);
         rx_done      = ($urandom_range(0, 24) == 0);
         tick_8x_in   = $urandom_range(0, 1) == 1;
         tick_baud_in = ($urandom_range(0, 5) == 0);
         rst          = ($urandom_range(0, 299) == 0);
         cyc();
      end
      rst = 0;
      quiet(2);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
